decode_prefix_sequencer: RTL

// - Sequences decode_stage_prefix (instantiated inside) over the prefetch-queue byte window.
// - Finds the leading run of prefix bytes each cycle, consumes it, and accumulates prefix state.

---
 rtl/decode_prefix_sequencer.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/decode_prefix_sequencer.sv
// Prefix sequencer: finds the leading prefix run in the queue window and accumulates it
// across windows into one registered record per instruction. Optional counters: DECODE_PREFIX_STATS_EN.

module decode_stage_prefix (
    input  logic [31:0] i_window,
    output logic [2:0]  o_consumed,
    output logic        o_lock,
    output logic        o_repne,
    output logic        o_rep,
    output logic        o_seg_override,
    output logic [2:0]  o_seg_index,
    output logic        o_operand_size,
    output logic        o_address_size,
    output logic [3:0]  o_groups,
    output logic        o_error
);
    logic       run;
    logic [7:0] b;
    logic [3:0] g;

    always_comb begin
        o_consumed     = 3'd0;
        o_lock         = 1'b0;
        o_repne        = 1'b0;
        o_rep          = 1'b0;
        o_seg_override = 1'b0;
        o_seg_index    = 3'd0;
        o_operand_size = 1'b0;
        o_address_size = 1'b0;
        o_groups       = 4'b0000;
        o_error        = 1'b0;
        run            = 1'b1;
        b              = 8'h00;
        g              = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            b = i_window[i*8 +: 8];
            case (b)
                8'hF0, 8'hF2, 8'hF3:                      g = 4'b0001;
                8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65: g = 4'b0010;
                8'h66:                                    g = 4'b0100;
                8'h67:                                    g = 4'b1000;
                default:                                  g = 4'b0000;
            endcase
            if (g == 4'b0000)
                run = 1'b0;
            if (run) begin
                // A second byte of an already-seen group inside one run is a duplicate
                if ((o_groups & g) != 4'b0000)
                    o_error = 1'b1;
                o_groups   = o_groups | g;
                o_consumed = o_consumed + 3'd1;
                case (b)
                    8'hF0: o_lock         = 1'b1;
                    8'hF2: o_repne        = 1'b1;
                    8'hF3: o_rep          = 1'b1;
                    8'h66: o_operand_size = 1'b1;
                    8'h67: o_address_size = 1'b1;
                    8'h26: begin o_seg_override = 1'b1; o_seg_index = 3'd0; end
                    8'h2E: begin o_seg_override = 1'b1; o_seg_index = 3'd1; end
                    8'h36: begin o_seg_override = 1'b1; o_seg_index = 3'd2; end
                    8'h3E: begin o_seg_override = 1'b1; o_seg_index = 3'd3; end
                    8'h64: begin o_seg_override = 1'b1; o_seg_index = 3'd4; end
                    8'h65: begin o_seg_override = 1'b1; o_seg_index = 3'd5; end
                    default: ;
                endcase
            end
        end
    end
endmodule

module decode_prefix_sequencer #(
    parameter int MAX_PREFIX_BYTES = 14
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] i_queue_byte,
    input  logic [2:0]  i_queue_count,
    output logic [2:0]  o_queue_consume,
    input  logic        i_flush,
    output logic        o_record_valid,
    input  logic        i_record_ready,
    output logic        o_lock,
    output logic        o_repne,
    output logic        o_rep,
    output logic        o_seg_override,
    output logic [2:0]  o_seg_index,
    output logic        o_operand_size,
    output logic        o_address_size,
    output logic [3:0]  o_prefix_count,
    output logic        o_fault,
    output logic [1:0]  o_fault_code
`ifdef DECODE_PREFIX_STATS_EN
    ,
    output logic [15:0] o_stat_records,
    output logic [15:0] o_stat_faults
`endif
);
    localparam logic [1:0] SCAN  = 2'd0;
    localparam logic [1:0] HOLD  = 2'd1;
    localparam logic [1:0] FAULT = 2'd2;
    localparam logic [1:0] CODE_DUP = 2'b01;
    localparam logic [1:0] CODE_LEN = 2'b10;
    localparam logic [4:0] MAX_BYTES = 5'(MAX_PREFIX_BYTES);

    logic [1:0]  state;
    logic [2:0]  eff_count;
    logic [31:0] stage_window;
    logic        keep;
    logic [7:0]  cur;

    // Flag vectors are {lock, repne, rep, seg_override, seg_index[2:0], operand, address}
    logic [8:0]  acc_flags, stg_flags, rec_flags;
    logic [3:0]  acc_groups, stg_groups, acc_count;
    logic [2:0]  stg_consumed;
    logic        stg_error;
    logic [4:0]  total_count;
    logic        dup_fault, len_fault, scan_go, enter_fault;

    assign eff_count = (i_queue_count > 3'd4) ? 3'd4 : i_queue_count;

    always_comb begin
        stage_window = {4{8'h90}};
        keep         = 1'b1;
        cur          = 8'h00;
        for (int i = 0; i < 4; i++) begin
            cur = i_queue_byte[i*8 +: 8];
            keep = keep && (3'(i) < eff_count) &&
                   (cur inside {8'hF0, 8'hF2, 8'hF3, 8'h26, 8'h2E, 8'h36,
                                8'h3E, 8'h64, 8'h65, 8'h66, 8'h67});
            if (keep)
                stage_window[i*8 +: 8] = cur;
        end
    end

    decode_stage_prefix u_stage (
        .i_window       (stage_window),
        .o_consumed     (stg_consumed),
        .o_lock         (stg_flags[8]),
        .o_repne        (stg_flags[7]),
        .o_rep          (stg_flags[6]),
        .o_seg_override (stg_flags[5]),
        .o_seg_index    (stg_flags[4:2]),
        .o_operand_size (stg_flags[1]),
        .o_address_size (stg_flags[0]),
        .o_groups       (stg_groups),
        .o_error        (stg_error)
    );

    assign total_count = {1'b0, acc_count} + {2'b00, stg_consumed};
    assign dup_fault   = stg_error || ((stg_groups & acc_groups) != 4'b0000);
    assign len_fault   = total_count > MAX_BYTES;
    assign scan_go     = (state == SCAN) && !i_flush && !reset && (eff_count != 3'd0);
    assign enter_fault = scan_go && (dup_fault || len_fault);

    assign o_queue_consume = (scan_go && !enter_fault) ? stg_consumed : 3'd0;
    assign o_record_valid  = (state == HOLD);
    assign o_fault         = (state == FAULT);
    assign {o_lock, o_repne, o_rep, o_seg_override, o_seg_index,
            o_operand_size, o_address_size} = rec_flags;

    // Record fields read as zero whenever no record is pending.
    // OR-merging seg_index is safe: a second segment byte always faults first.
    always_ff @(posedge clock or posedge reset) begin
        if (reset || i_flush) begin
            state          <= SCAN;
            acc_flags      <= '0;
            acc_groups     <= '0;
            acc_count      <= '0;
            rec_flags      <= '0;
            o_prefix_count <= '0;
            o_fault_code   <= '0;
        end else begin
            case (state)
                SCAN: begin
                    if (eff_count != 3'd0) begin
                        if (dup_fault) begin
                            state        <= FAULT;
                            o_fault_code <= CODE_DUP;
                        end else if (len_fault) begin
                            state        <= FAULT;
                            o_fault_code <= CODE_LEN;
                        end else if (stg_consumed == eff_count) begin
                            acc_flags  <= acc_flags | stg_flags;
                            acc_groups <= acc_groups | stg_groups;
                            acc_count  <= total_count[3:0];
                        end else begin
                            rec_flags      <= acc_flags | stg_flags;
                            o_prefix_count <= total_count[3:0];
                            acc_flags      <= '0;
                            acc_groups     <= '0;
                            acc_count      <= '0;
                            state          <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (i_record_ready) begin
                        rec_flags      <= '0;
                        o_prefix_count <= '0;
                        state          <= SCAN;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DECODE_PREFIX_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            o_stat_records <= '0;
            o_stat_faults  <= '0;
        end else begin
            if ((state == HOLD) && i_record_ready && !i_flush && (o_stat_records != 16'hFFFF))
                o_stat_records <= o_stat_records + 16'd1;
            if (enter_fault && (o_stat_faults != 16'hFFFF))
                o_stat_faults <= o_stat_faults + 16'd1;
        end
    end
`endif
endmodule
